// File: rtl/gpio_irq_svc.sv
// gpio_irq_svc: shares the gpio register port between CPU accesses and a service engine that
// snapshots and losslessly clears gpio IRQ_V, queueing {vector, timestamp} events in a FIFO.
module gpio_irq_svc #(
  parameter int unsigned gpio_w     = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_W       = 16,
  parameter logic [4:0]  IRQ_V_ADDR = 5'h14
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cpu_req,
  input  logic [4:0]             cpu_addr,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_wd,
  output logic [31:0]            cpu_rd,
  output logic                   cpu_ack,
  output logic [4:0]             g_addr,
  output logic                   g_we,
  output logic [31:0]            g_wd,
  input  logic [31:0]            g_rd,
  input  logic                   g_irq,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [gpio_w-1:0]      ev_vec,
  output logic [TS_W-1:0]        ev_ts,
  output logic [$clog2(DEPTH):0] ev_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSnap = 2'd1;
  localparam logic [1:0] StClr  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_svc_q, last_svc_d;  // 1: service engine won the last grant
  logic [gpio_w-1:0] snap_q, snap_d;
  logic [TS_W-1:0]   ts_snap_q, ts_snap_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic [gpio_w-1:0] vec_mem_q [DEPTH];
  logic [TS_W-1:0]   ts_mem_q  [DEPTH];

  logic        svc_req;
  logic        cpu_ack_c;
  logic        g_we_c;
  logic        push;
  logic        pop;
  logic [31:0] clr_wd;

  assign svc_req = g_irq && (cnt_q < DepthC);
  assign pop     = ev_ready && (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    last_svc_d = last_svc_q;
    snap_d     = snap_q;
    ts_snap_d  = ts_snap_q;
    cpu_ack_c  = 1'b0;
    g_we_c     = 1'b0;
    g_addr     = cpu_addr;
    g_wd       = cpu_wd;
    push       = 1'b0;
    // Keep bits captured after the snapshot; clear only what was snapped.
    clr_wd             = '0;
    clr_wd[gpio_w-1:0] = g_rd[gpio_w-1:0] & ~snap_q;

    case (state_q)
      StIdle: begin
        if (cpu_req && (!svc_req || last_svc_q)) begin
          cpu_ack_c  = 1'b1;
          last_svc_d = 1'b0;
        end else if (svc_req) begin
          last_svc_d = 1'b1;
          state_d    = StSnap;
        end
        g_we_c = cpu_we & cpu_ack_c;
      end
      StSnap: begin
        g_addr    = IRQ_V_ADDR;
        snap_d    = g_rd[gpio_w-1:0];
        ts_snap_d = ts_q;
        state_d   = (g_rd[gpio_w-1:0] != '0) ? StClr : StIdle;
      end
      StClr: begin
        g_addr  = IRQ_V_ADDR;
        g_wd    = clr_wd;
        g_we_c  = 1'b1;
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    valid_d  = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      last_svc_q <= 1'b1;
      snap_q     <= '0;
      ts_snap_q  <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_svc_q <= last_svc_d;
      snap_q     <= snap_d;
      ts_snap_q  <= ts_snap_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      vec_mem_q[wr_ptr_q] <= snap_q;
      ts_mem_q[wr_ptr_q]  <= ts_snap_q;
    end
  end

  // Reset overrides any bus activity so an abandoned CLR never reaches the gpio.
  assign cpu_ack  = cpu_ack_c & rstn;
  assign g_we     = g_we_c & rstn;
  assign cpu_rd   = g_rd;
  assign ev_valid = valid_q;
  assign ev_vec   = vec_mem_q[rd_ptr_q];
  assign ev_ts    = ts_mem_q[rd_ptr_q];
  assign ev_cnt   = cnt_q;

endmodule

// File: tb/tb_gpio_irq_svc.sv
// Bench for gpio_irq_svc: behavioural gpio register model, directed scenarios and a randomized
// phase checked by per-pin pending-episode accounting.
module tb_gpio_irq_svc;
  localparam logic [4:0] IRQ_A = 5'h14;
  localparam logic [4:0] GPO_A = 5'h04;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_wd = '0;
  logic [31:0] cpu_rd;
  logic        cpu_ack;
  logic [4:0]  g_addr;
  logic        g_we;
  logic [31:0] g_wd;
  logic [31:0] g_rd;
  logic        g_irq;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [7:0]  ev_vec;
  logic [3:0]  ev_ts;
  logic [2:0]  ev_cnt;

  always #5 clk = ~clk;

  gpio_irq_svc #(
    .gpio_w     (8),
    .DEPTH      (4),
    .TS_W       (4),
    .IRQ_V_ADDR (IRQ_A)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .cpu_ack  (cpu_ack),
    .g_addr   (g_addr),
    .g_we     (g_we),
    .g_wd     (g_wd),
    .g_rd     (g_rd),
    .g_irq    (g_irq),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_vec   (ev_vec),
    .ev_ts    (ev_ts),
    .ev_cnt   (ev_cnt)
  );

  // gpio model: plain registers, IRQ_V is read/write and ORs in edge captures every cycle.
  logic [31:0] gregs [32] = '{default: '0};
  logic [7:0]  irq_v = '0;
  logic [7:0]  cap = '0;
  int          ep [8] = '{default: 0};
  wire  [7:0]  irq_base = (g_we && g_addr == IRQ_A) ? g_wd[7:0] : irq_v;

  assign g_rd  = (g_addr == IRQ_A) ? {24'h0, irq_v} : gregs[g_addr];
  assign g_irq = |irq_v;

  always @(posedge clk) begin
    if (g_we && g_addr != IRQ_A) gregs[g_addr] <= g_wd;
    for (int p = 0; p < 8; p++) if (cap[p] && !irq_base[p]) ep[p] <= ep[p] + 1;
    irq_v <= irq_base | cap;
  end

  // Timestamp reference: counts cycles since the last reset edge.
  logic [3:0] mts = '0;
  always @(posedge clk) mts <= rstn ? mts + 4'd1 : 4'd0;

  int total = 0;
  int bad = 0;
  int rep [8] = '{default: 0};
  int gwr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cap = '0;
  endtask

  task automatic obs();
    #1;
    if (ev_valid && ev_ready)
      for (int p = 0; p < 8; p++) rep[p] += int'(ev_vec[p]);
    if (g_we && g_addr == IRQ_A) gwr++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin nxt(); obs(); end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] v, input logic [3:0] ts,
                         input bit ck_ts);
    nxt(); ev_ready = 1'b1; obs();
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_vec"}, ev_vec, v);
    if (ck_ts) chk({tag, "_ts"}, ev_ts, ts);
    nxt(); ev_ready = 1'b0; obs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  exp_ts;
    logic [31:0] shadow [4];
    logic [31:0] rd;
    int          st, max_st, acks, gwr0, wrs;
    int          ep_b [8];
    int          rep_b [8];
    bit          done;

    // Reset with a CPU request pending: nothing may be acked or written.
    rstn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = GPO_A; cpu_wd = 32'hA5;
    idle(3);
    chk("rst_cnt", ev_cnt, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_we", g_we, 0);

    // First cycle out of reset: uncontended CPU write passes straight through.
    nxt(); rstn = 1'b1; obs();
    chk("cpu_ack0", cpu_ack, 1);
    chk("cpu_wr_bus", {g_we, g_addr, g_wd}, {1'b1, GPO_A, 32'hA5} & 32'hFFFF_FFFF);
    chk("cpu_wr_wd", g_wd, 32'hA5);

    // Contention after a CPU grant: service wins, CPU stalls through SNAP and CLR.
    nxt(); cpu_req = 1'b0; cap = 8'h01; obs();
    nxt(); cpu_req = 1'b1; cpu_we = 1'b0; obs();
    chk("arb_svc_win", cpu_ack, 0);
    chk("arb_svc_we", g_we, 0);
    nxt(); obs();
    chk("arb_snap_ack", cpu_ack, 0);
    chk("arb_snap_addr", g_addr, IRQ_A);
    nxt(); obs();
    chk("arb_clr_ack", cpu_ack, 0);
    chk("arb_clr_we", g_we, 1);
    nxt(); obs();
    chk("arb_cpu_after", cpu_ack, 1);
    chk("arb_cpu_rd", cpu_rd, 32'hA5);
    // Service alone, then contention right after it: CPU must win this time.
    nxt(); cpu_req = 1'b0; cap = 8'h02; obs();
    idle(2);
    nxt(); cap = 8'h04; obs();
    nxt(); cpu_req = 1'b1; obs();
    chk("arb_cpu_win", cpu_ack, 1);
    nxt(); obs();
    chk("arb_svc_turn", cpu_ack, 0);
    nxt(); cpu_req = 1'b0; obs();
    idle(4);
    chk("arb_cnt", ev_cnt, 3);
    pop_chk("arb_e1", 8'h01, 4'h0, 1'b0);
    pop_chk("arb_e2", 8'h02, 4'h0, 1'b0);
    pop_chk("arb_e3", 8'h04, 4'h0, 1'b0);

    // Continuous CPU requests against repeated interrupts.
    ev_ready = 1'b1; max_st = 0; acks = 0; gwr0 = gwr;
    for (int i = 0; i < 12; i++) begin
      nxt();
      cap = 8'(1 << (i % 8));
      cpu_req = 1'b1; cpu_we = (i % 2 == 0); cpu_addr = GPO_A; cpu_wd = 32'hA5;
      obs();
      st = 0;
      while (!cpu_ack && st < 8) begin nxt(); obs(); st++; end
      if (cpu_ack) acks++;
      if (st > max_st) max_st = st;
      if (cpu_we) chk("cont_wd", g_wd, 32'hA5);
      else chk("cont_rd", cpu_rd, 32'hA5);
    end
    nxt(); cpu_req = 1'b0; obs();
    idle(10);
    ev_ready = 1'b0;
    chk("cont_stall_le3", {31'b0, max_st <= 3}, 1);
    chk("cont_acks", acks, 12);
    chk("cont_svc_alt", {31'b0, (gwr - gwr0) >= 5}, 1);
    chk("cont_gpo", gregs[GPO_A], 32'hA5);
    chk("cont_drained", ev_cnt, 0);

    // Single edge on pin 2.
    nxt(); cap = 8'h04; obs();
    nxt(); obs();
    chk("se_irq", g_irq, 1);
    nxt(); obs();
    exp_ts = mts;
    chk("se_snap", {g_we, g_addr}, {1'b0, IRQ_A});
    nxt(); obs();
    chk("se_clr", {g_we, g_addr}, {1'b1, IRQ_A});
    chk("se_clr_wd", g_wd, 0);
    chk("se_not_yet", ev_valid, 0);
    nxt(); obs();
    chk("se_valid", ev_valid, 1);
    chk("se_vec", ev_vec, 8'h04);
    chk("se_ts", ev_ts, exp_ts);
    chk("se_irq_low", g_irq, 0);
    pop_chk("se_pop", 8'h04, exp_ts, 1'b1);
    chk("se_empty", ev_cnt, 0);

    // Race: pin 5 lands while pin 0 is being serviced.
    nxt(); cap = 8'h01; obs();
    nxt(); obs();
    nxt(); cap = 8'h20; obs();
    nxt(); obs();
    chk("race_clr_wd", g_wd, 32'h20);
    idle(6);
    chk("race_cnt", ev_cnt, 2);
    pop_chk("race_e1", 8'h01, 4'h0, 1'b0);
    pop_chk("race_e2", 8'h20, 4'h0, 1'b0);

    // Full FIFO: pins 1 and 2 must wait in IRQ_V until space frees.
    for (int i = 0; i < 4; i++) begin
      nxt(); cap = 8'(8'h10 << i); obs();
      idle(4);
    end
    chk("full_cnt", ev_cnt, 4);
    nxt(); cap = 8'h06; obs();
    wrs = gwr;
    idle(8);
    chk("full_no_wr", gwr - wrs, 0);
    chk("full_irq", g_irq, 1);
    chk("full_irqv", irq_v, 8'h06);
    pop_chk("full_e1", 8'h10, 4'h0, 1'b0);
    idle(6);
    chk("full_refill", ev_cnt, 4);
    pop_chk("full_e2", 8'h20, 4'h0, 1'b0);
    pop_chk("full_e3", 8'h40, 4'h0, 1'b0);
    pop_chk("full_e4", 8'h80, 4'h0, 1'b0);
    pop_chk("full_e5", 8'h06, 4'h0, 1'b0);
    chk("full_empty", ev_cnt, 0);

    // Timestamp wrap: snapshots at ts 15 and then ts 0.
    for (int i = 0; i < 40; i++) begin
      nxt();
      if (mts == 4'd13) begin cap = 8'h08; obs(); break; end
      obs();
    end
    idle(4);
    for (int i = 0; i < 40; i++) begin
      nxt();
      if (mts == 4'd14) begin cap = 8'h10; obs(); break; end
      obs();
    end
    idle(5);
    pop_chk("wrap_e1", 8'h08, 4'd15, 1'b1);
    pop_chk("wrap_e2", 8'h10, 4'd0, 1'b1);

    // Reset held two cycles across a CLR: no write, no push, IRQ_V kept.
    nxt(); cap = 8'h08; obs();
    nxt(); obs();
    nxt(); obs();
    nxt(); rstn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = GPO_A; obs();
    chk("rclr_we", g_we, 0);
    chk("rclr_ack", cpu_ack, 0);
    nxt(); obs();
    chk("rclr_cnt", ev_cnt, 0);
    chk("rclr_valid", ev_valid, 0);
    chk("rclr_irqv", irq_v, 8'h08);
    nxt(); rstn = 1'b1; obs();
    chk("rclr_idle_cpu", cpu_ack, 1);
    nxt(); cpu_req = 1'b0; obs();
    idle(4);
    pop_chk("rclr_e1", 8'h08, 4'h0, 1'b0);

    // Randomized traffic: every pending episode of every pin must be reported exactly once.
    for (int p = 0; p < 8; p++) begin ep_b[p] = ep[p]; rep_b[p] = rep[p]; end
    for (int a = 0; a < 4; a++) shadow[a] = '0;
    done = 1'b0; st = 0;
    for (int i = 0; i < 800; i++) begin
      nxt();
      if ($urandom_range(5) == 0) cap = 8'($urandom_range(1, 255));
      ev_ready = ($urandom_range(1) == 1);
      if (done) begin cpu_req = 1'b0; done = 1'b0; end
      else if (!cpu_req && $urandom_range(2) == 0) begin
        cpu_req = 1'b1; cpu_we = ($urandom_range(1) == 1);
        cpu_addr = 5'($urandom_range(3)); cpu_wd = $urandom; st = 0;
      end
      obs();
      if (cpu_req) begin
        if (cpu_ack) begin
          if (cpu_we) shadow[cpu_addr[1:0]] = cpu_wd;
          else chk("rnd_rd", cpu_rd, shadow[cpu_addr[1:0]]);
          chk("rnd_stall", {31'b0, st <= 3}, 1);
          done = 1'b1;
        end else st++;
      end
    end
    nxt(); cpu_req = 1'b0; ev_ready = 1'b1; obs();
    idle(60);
    chk("rnd_irq_quiet", g_irq, 0);
    chk("rnd_drained", ev_cnt, 0);
    for (int p = 0; p < 8; p++)
      chk($sformatf("rnd_pin%0d_episodes", p), rep[p] - rep_b[p], ep[p] - ep_b[p]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_irq_svc.md
# gpio_irq_svc

Hardware interrupt-service controller placed between the CPU register bus and one gpio instance. It shares the gpio register port between CPU accesses and an internal service engine. On gpio irq the engine snapshots and losslessly clears the IRQ_V register, then queues {pending vector, timestamp} events in a small FIFO for software to drain. Software no longer races edge captures with read-modify-write sequences on IRQ_V.

## Interface
- gpio_w, 8, gpio width; must equal the attached gpio gpio_w
- DEPTH, 4, event FIFO depth; power of 2, ≥2
- TS_W, 16, timestamp width
- IRQ_V_ADDR, 5'h14, gpio IRQ_V register address; must equal GPIO_IRQ_V of the gpio register map
- clk  in  1  clock; single clock domain
- rstn  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_addr  in  5  CPU register address
- cpu_we  in  1  CPU write enable
- cpu_wd  in  32  CPU write data
- cpu_rd  out  32  CPU read data; valid when cpu_ack=1
- cpu_ack  out  1  access performed this cycle
- g_addr  out  5  to gpio addr
- g_we  out  1  to gpio we
- g_wd  out  32  to gpio wd
- g_rd  in  32  from gpio rd (combinational in gpio)
- g_irq  in  1  from gpio irq
- ev_valid  out  1  FIFO not empty; also usable as CPU interrupt
- ev_ready  in  1  pop; acts only when ev_valid=1
- ev_vec  out  gpio_w  head event pending-pin vector
- ev_ts  out  TS_W  head event timestamp
- ev_cnt  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states: IDLE, SNAP, CLR.
- IDLE: gpio bus defaults to CPU passthrough (g_addr=cpu_addr, g_wd=cpu_wd). g_we=cpu_we&cpu_ack. cpu_rd=g_rd.
  - svc_req = g_irq & (ev_cnt<DEPTH).
  - Only cpu_req: cpu_ack=1 this cycle.
  - Only svc_req: cpu_ack=0, g_we=0, next SNAP.
  - Both: the requester not granted last time wins (last_grant flag, reset value = service). CPU win: ack now. Service win: CPU stalls.
- SNAP: g_addr=IRQ_V_ADDR, g_we=0, cpu_ack=0. snap<=g_rd[gpio_w-1:0]. ts_snap<=ts. Next CLR if g_rd[gpio_w-1:0]≠0, else IDLE with no push (spurious).
- CLR: g_addr=IRQ_V_ADDR, g_we=1, cpu_ack=0.
  - g_wd={'0, g_rd[gpio_w-1:0] & ~snap}. Bits set by a capture after SNAP are rewritten as 1, so no event is lost.
  - Push {snap, ts_snap}. Next IDLE.
- g_irq with FIFO full: no service. Pins stay pending in gpio IRQ_V and merge. They are serviced once space frees.
- ts: free-running TS_W counter, +1 per cycle, wraps to 0.
- FIFO: circular, DEPTH entries. A pop with ev_valid=0 is ignored. Push and pop in the same cycle keep the count. Push never happens while full, because fullness is checked in IDLE and only one push per service.
- The CPU is never granted in SNAP/CLR. Maximum CPU stall is 3 cycles when the service wins arbitration.

## Timing
- Reset (rstn=0 at a clk edge): state=IDLE, FIFO empty, ev_valid=0, ev_cnt=0, ts=0, last_grant=service. While rstn=0: g_we=0, cpu_ack=0.
  - Reset mid-service abandons it with no push and no write. The gpio IRQ_V is untouched unless the gpio itself is reset.
- g_irq high in IDLE cycle T (no CPU contention):
  - SNAP at T+1.
  - CLR write at T+2.
  - ev_valid=1 at T+3.
  - g_irq low at T+3 if no new capture.
- Back-to-back captures: a new pin captured at or after the SNAP edge stays pending. It is serviced in a new IDLE→SNAP pass, as a separate event.
- CPU access: one cycle, combinational ack, zero wait in uncontended IDLE.
- ev_vec/ev_ts/ev_valid are registered FIFO head outputs. The new head appears the cycle after a pop.

## Test plan
- Reset: hold rstn=0 for 2 cycles during a CLR → ev_cnt=0, g_we=0, state IDLE, and gpio IRQ_V keeps its value.
- Single edge: IRQ_V becomes 8'h04 at T → g_wd=0 written at T+2, then ev_vec=8'h04 and ev_ts=ts(T+1) with ev_valid at T+3.
- Race: pin 0 pending, pin 5 captured at the SNAP edge → CLR writes 8'h20 and event 1 has vector 8'h01. Second pass gives event 2 with vector 8'h20.
- Full FIFO (DEPTH=4): queue 4 events, then trigger pins 1 and 2 → no service and g_irq stays high. After one pop, one event with ev_vec=8'h06 is queued.
- Arbitration: cpu_req held continuously with repeated irq → grants alternate. CPU waits ≤3 cycles, and the CPU write of GPO=8'hA5 reaches the gpio intact.
- Timestamp wrap (TS_W=4): event at ts=15 then ts=0 → ev_ts values 15 and 0, in order.
